dram_timing_guard: RTL
======================

# dram_timing_guard

Parametrised per-bank DDR4 timing checker between the scheduler buffer and the DRAM command generator. It tracks open/closed state and every inter-command timing constraint across all bank groups and banks. It reports per-command legality for a queried bank, and accepts or rejects each issued command. It generalises the fixed single-set timing constants to configurable bank-group/bank counts and adds a rolling four-activate (tFAW) window.

## Interface
- BANK_GROUPS, 4, number of bank groups (≥1)
- BANKS_PER_GROUP, 4, banks per group (≥1)
- CNT_W, 8, timing counter width; every timing parameter must be ≤ 2^CNT_W
- tRCD, 12, ACT→RD/WR same bank
- tRP, 10, PRE→ACT same bank
- tRAS, 17, ACT→PRE same bank
- tCCD_S, 4 / tCCD_L, 5, column→column, different / same bank group
- tRRD_S, 4 / tRRD_L, 4, ACT→ACT, different / same bank group
- tFAW, 35, window in which at most 4 ACTs are allowed
- tWTR, 12, WR→RD, any bank

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command issued this cycle
- cmd_type  in  3  0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE; other values are treated as NOP
- cmd_bg  in  clog2(BANK_GROUPS)  target bank group
- cmd_ba  in  clog2(BANKS_PER_GROUP)  target bank
- query_bg, query_ba  in  same widths  bank queried for legality
- act_ok, rd_ok, wr_ok, pre_ok  out  1  combinational legality for the queried bank this cycle
- cmd_accept  out  1  combinational; cmd_valid, non-NOP, and legal
- cmd_violation  out  1  registered; pulses the cycle after an illegal non-NOP command
- bank_open  out  BANK_GROUPS*BANKS_PER_GROUP  open flag; index is bg*BANKS_PER_GROUP+ba

## Operation
- Counter semantics:
  - Each constraint is a saturating down-counter, with 0 meaning satisfied.
  - An accepted command loads the counter with T-1 in the same cycle, so the earliest legal follow-up is cycle t+T.
  - A load has priority over a decrement.
- Per-bank counters: rcd, ras, rp.
- Per-bank-group counters: ccd_l, rrd_l.
- Global counters: ccd_s, rrd_s, wtr.
- FAW tracking: four window counters. An accepted ACT loads tFAW-1 into one zero-valued slot. faw_busy is the number of non-zero slots.
- Legality:
  - ACT: bank closed ∧ rp=0 ∧ rrd_s=0 ∧ rrd_l[bg]=0 ∧ faw_busy<4.
  - RD: bank open ∧ rcd=0 ∧ ccd_s=0 ∧ ccd_l[bg]=0 ∧ wtr=0.
  - WR: bank open ∧ rcd=0 ∧ ccd_s=0 ∧ ccd_l[bg]=0.
  - PRE: bank open ∧ ras=0. PRE to a closed bank is illegal.
- Effects of an accepted command:
  - ACT: sets bank_open; loads rcd, ras, rrd_s, rrd_l[bg] and one FAW slot.
  - RD: loads ccd_s, ccd_l[bg].
  - WR: loads ccd_s, ccd_l[bg], wtr.
  - PRE: clears bank_open; loads rp.
- Illegal command: no state change at all (counters continue to decrement); cmd_violation=1 on the next cycle.
- The query port and the command port are independent. The ok outputs reflect state before the current cycle's command.
- There is one command per cycle, so simultaneous commands cannot occur.

## Timing
- Reset (async assert on nRST low, sync release): all counters 0, bank_open all 0, cmd_violation 0.
- Output values while in reset: act_ok=1, rd_ok=wr_ok=pre_ok=0, cmd_accept follows the ACT rule.
- Latency:
  - Legality and acceptance are 0 cycles (combinational from registered state).
  - State update is visible at the next rising edge.
  - cmd_violation is 1 cycle after the offending command.
- Reset mid-operation: all banks are immediately reported closed and all timing is forgotten. An ACT in the first cycle after release is accepted.
- Counter wrap is impossible: loads are bounded by parameters, and decrements stop at 0.
- FAW: if four slots are busy, the 5th ACT becomes legal the cycle the oldest slot reaches 0.

## Test plan
- Activate-to-read:
  - ACT bg0/ba0 at cycle 0 -> accepted, bank_open[0]=1.
  - RD bg0/ba0 at cycle 11 -> cmd_accept=0, violation at 12.
  - RD at cycle 12 -> accepted.
- Activate-to-precharge and precharge-to-activate:
  - ACT bg1/ba2 at 0; PRE at 16 -> rejected; PRE at 17 -> accepted, bank_open[6]=0.
  - ACT at 26 -> rejected; ACT at 27 -> accepted.
- Column spacing by bank group (bg0/ba0 and bg1/ba0 open, timing met):
  - RD bg0 at t; RD bg0 at t+4 -> rejected (tCCD_L=5).
  - RD bg1 at t+4 -> accepted.
- Write-to-read: WR bg0/ba0 at t; RD bg2 at t+11 -> rejected; RD at t+12 -> accepted.
- Four-activate window:
  - ACTs to bg0..bg3 ba0 at cycles 0, 4, 8, 12 -> all accepted.
  - ACT bg0/ba1 at 16 -> rejected, act_ok=0 when queried through cycle 34.
  - The same ACT at 35 -> accepted.
- Reset mid-operation:
  - With 3 banks open and counters running, pulse nRST low -> bank_open=0, cmd_violation=0.
  - After release, ACT bg0/ba0 at the first cycle -> accepted.
  - PRE to a closed bank -> rejected with violation.

Source files
------------

// File: rtl/dram_timing_guard.sv
// -----------------------------------------------------------------------------
// dram_timing_guard
//
// Per-bank DDR4 timing checker sitting between the scheduler buffer and the
// DRAM command generator. It keeps the open/closed state of every bank and a
// saturating down-counter for every inter-command constraint (0 = satisfied).
// It answers legality queries for one bank and accepts or rejects the command
// issued in the current cycle.
//
// Ports
//   CLK            clock
//   nRST           asynchronous active-low reset
//   cmd_valid      a command is issued this cycle
//   cmd_type       0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, others = NOP
//   cmd_bg/cmd_ba  target bank group / bank of the issued command
//   query_bg/ba    bank whose legality is reported on the *_ok outputs
//   act_ok..pre_ok combinational legality for the queried bank
//   cmd_accept     combinational: valid, non-NOP and legal
//   cmd_violation  registered: pulses the cycle after an illegal command
//   bank_open      open flag per bank, index bg*BANKS_PER_GROUP+ba
// -----------------------------------------------------------------------------
module dram_timing_guard #(
    parameter int BANK_GROUPS     = 4,
    parameter int BANKS_PER_GROUP = 4,
    parameter int CNT_W           = 8,
    parameter int tRCD            = 12,
    parameter int tRP             = 10,
    parameter int tRAS            = 17,
    parameter int tCCD_S          = 4,
    parameter int tCCD_L          = 5,
    parameter int tRRD_S          = 4,
    parameter int tRRD_L          = 4,
    parameter int tFAW            = 35,
    parameter int tWTR            = 12,
    localparam int BG_W = (BANK_GROUPS > 1) ? $clog2(BANK_GROUPS) : 1,
    localparam int BA_W = (BANKS_PER_GROUP > 1) ? $clog2(BANKS_PER_GROUP) : 1,
    localparam int NB   = BANK_GROUPS * BANKS_PER_GROUP
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            cmd_valid,
    input  logic [2:0]      cmd_type,
    input  logic [BG_W-1:0] cmd_bg,
    input  logic [BA_W-1:0] cmd_ba,
    input  logic [BG_W-1:0] query_bg,
    input  logic [BA_W-1:0] query_ba,
    output logic            act_ok,
    output logic            rd_ok,
    output logic            wr_ok,
    output logic            pre_ok,
    output logic            cmd_accept,
    output logic            cmd_violation,
    output logic [NB-1:0]   bank_open
);

    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [2:0] CMD_ACT = 3'd1;
    localparam logic [2:0] CMD_RD  = 3'd2;
    localparam logic [2:0] CMD_WR  = 3'd3;
    localparam logic [2:0] CMD_PRE = 3'd4;

    localparam logic [CNT_W-1:0] ONE = 1;

    // Load value T-1 so that the earliest legal follow-up is exactly T cycles
    // after the loading command.
    function automatic logic [CNT_W-1:0] ld_val(input int t);
        return (t > 0) ? CNT_W'(t - 1) : '0;
    endfunction

    function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] x);
        return (x == '0) ? '0 : x - ONE;
    endfunction

    localparam logic [CNT_W-1:0] RCD_LD   = ld_val(tRCD);
    localparam logic [CNT_W-1:0] RP_LD    = ld_val(tRP);
    localparam logic [CNT_W-1:0] RAS_LD   = ld_val(tRAS);
    localparam logic [CNT_W-1:0] CCDS_LD  = ld_val(tCCD_S);
    localparam logic [CNT_W-1:0] CCDL_LD  = ld_val(tCCD_L);
    localparam logic [CNT_W-1:0] RRDS_LD  = ld_val(tRRD_S);
    localparam logic [CNT_W-1:0] RRDL_LD  = ld_val(tRRD_L);
    localparam logic [CNT_W-1:0] FAW_LD   = ld_val(tFAW);
    localparam logic [CNT_W-1:0] WTR_LD   = ld_val(tWTR);

    // State
    logic [NB-1:0]    bank_open_q, bank_open_d;
    logic             cmd_violation_q, cmd_violation_d;
    logic [CNT_W-1:0] rcd_q [NB];
    logic [CNT_W-1:0] rcd_d [NB];
    logic [CNT_W-1:0] ras_q [NB];
    logic [CNT_W-1:0] ras_d [NB];
    logic [CNT_W-1:0] rp_q  [NB];
    logic [CNT_W-1:0] rp_d  [NB];
    logic [CNT_W-1:0] ccd_l_q [BANK_GROUPS];
    logic [CNT_W-1:0] ccd_l_d [BANK_GROUPS];
    logic [CNT_W-1:0] rrd_l_q [BANK_GROUPS];
    logic [CNT_W-1:0] rrd_l_d [BANK_GROUPS];
    logic [CNT_W-1:0] ccd_s_q, ccd_s_d;
    logic [CNT_W-1:0] rrd_s_q, rrd_s_d;
    logic [CNT_W-1:0] wtr_q, wtr_d;
    logic [CNT_W-1:0] faw_q [4];
    logic [CNT_W-1:0] faw_d [4];

    // Per-bank legality, evaluated from registered state only
    logic [NB-1:0] act_leg, rd_leg, wr_leg, pre_leg;
    logic [2:0]    faw_busy;

    always_comb begin
        faw_busy = 3'd0;
        for (int s = 0; s < 4; s++) begin
            if (faw_q[s] != '0) faw_busy = faw_busy + 3'd1;
        end
        act_leg = '0;
        rd_leg  = '0;
        wr_leg  = '0;
        pre_leg = '0;
        for (int g = 0; g < BANK_GROUPS; g++) begin
            for (int b = 0; b < BANKS_PER_GROUP; b++) begin
                act_leg[g*BANKS_PER_GROUP+b] = !bank_open_q[g*BANKS_PER_GROUP+b]
                    && (rp_q[g*BANKS_PER_GROUP+b] == '0)
                    && (rrd_s_q == '0) && (rrd_l_q[g] == '0)
                    && (faw_busy < 3'd4);
                wr_leg[g*BANKS_PER_GROUP+b] = bank_open_q[g*BANKS_PER_GROUP+b]
                    && (rcd_q[g*BANKS_PER_GROUP+b] == '0)
                    && (ccd_s_q == '0) && (ccd_l_q[g] == '0);
                rd_leg[g*BANKS_PER_GROUP+b] = wr_leg[g*BANKS_PER_GROUP+b]
                    && (wtr_q == '0);
                pre_leg[g*BANKS_PER_GROUP+b] = bank_open_q[g*BANKS_PER_GROUP+b]
                    && (ras_q[g*BANKS_PER_GROUP+b] == '0);
            end
        end
    end

    // Query and command bank decode. Out-of-range addresses (non power-of-two
    // geometries) are never legal.
    logic             q_in, c_in;
    logic [IDX_W-1:0] q_idx, c_idx;
    logic             is_act, is_rd, is_wr, is_pre;
    logic             acc_act, acc_rd, acc_wr, acc_pre;

    always_comb begin
        q_in  = (int'(query_bg) < BANK_GROUPS) && (int'(query_ba) < BANKS_PER_GROUP);
        q_idx = IDX_W'(int'(query_bg) * BANKS_PER_GROUP + int'(query_ba));
        c_in  = (int'(cmd_bg) < BANK_GROUPS) && (int'(cmd_ba) < BANKS_PER_GROUP);
        c_idx = IDX_W'(int'(cmd_bg) * BANKS_PER_GROUP + int'(cmd_ba));

        act_ok = q_in && act_leg[q_idx];
        rd_ok  = q_in && rd_leg[q_idx];
        wr_ok  = q_in && wr_leg[q_idx];
        pre_ok = q_in && pre_leg[q_idx];

        is_act = cmd_valid && (cmd_type == CMD_ACT);
        is_rd  = cmd_valid && (cmd_type == CMD_RD);
        is_wr  = cmd_valid && (cmd_type == CMD_WR);
        is_pre = cmd_valid && (cmd_type == CMD_PRE);

        acc_act = is_act && c_in && act_leg[c_idx];
        acc_rd  = is_rd  && c_in && rd_leg[c_idx];
        acc_wr  = is_wr  && c_in && wr_leg[c_idx];
        acc_pre = is_pre && c_in && pre_leg[c_idx];

        cmd_accept      = acc_act || acc_rd || acc_wr || acc_pre;
        cmd_violation_d = (is_act || is_rd || is_wr || is_pre) && !cmd_accept;
    end

    // Next state: every counter decrements, then accepted commands load
    // (a load overrides the decrement). Rejected commands change nothing.
    logic faw_found;

    always_comb begin
        bank_open_d = bank_open_q;
        for (int i = 0; i < NB; i++) begin
            rcd_d[i] = sat_dec(rcd_q[i]);
            ras_d[i] = sat_dec(ras_q[i]);
            rp_d[i]  = sat_dec(rp_q[i]);
        end
        for (int g = 0; g < BANK_GROUPS; g++) begin
            ccd_l_d[g] = sat_dec(ccd_l_q[g]);
            rrd_l_d[g] = sat_dec(rrd_l_q[g]);
        end
        ccd_s_d = sat_dec(ccd_s_q);
        rrd_s_d = sat_dec(rrd_s_q);
        wtr_d   = sat_dec(wtr_q);
        for (int s = 0; s < 4; s++) begin
            faw_d[s] = sat_dec(faw_q[s]);
        end
        faw_found = 1'b0;

        if (acc_act) begin
            bank_open_d[c_idx] = 1'b1;
            rcd_d[c_idx]       = RCD_LD;
            ras_d[c_idx]       = RAS_LD;
            rrd_s_d            = RRDS_LD;
            rrd_l_d[cmd_bg]    = RRDL_LD;
            // Legality guarantees at least one idle window slot exists.
            for (int s = 0; s < 4; s++) begin
                if (!faw_found && (faw_q[s] == '0)) begin
                    faw_d[s]  = FAW_LD;
                    faw_found = 1'b1;
                end
            end
        end
        if (acc_rd || acc_wr) begin
            ccd_s_d         = CCDS_LD;
            ccd_l_d[cmd_bg] = CCDL_LD;
        end
        if (acc_wr) begin
            wtr_d = WTR_LD;
        end
        if (acc_pre) begin
            bank_open_d[c_idx] = 1'b0;
            rp_d[c_idx]        = RP_LD;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            bank_open_q     <= '0;
            cmd_violation_q <= 1'b0;
            for (int i = 0; i < NB; i++) begin
                rcd_q[i] <= '0;
                ras_q[i] <= '0;
                rp_q[i]  <= '0;
            end
            for (int g = 0; g < BANK_GROUPS; g++) begin
                ccd_l_q[g] <= '0;
                rrd_l_q[g] <= '0;
            end
            ccd_s_q <= '0;
            rrd_s_q <= '0;
            wtr_q   <= '0;
            for (int s = 0; s < 4; s++) begin
                faw_q[s] <= '0;
            end
        end else begin
            bank_open_q     <= bank_open_d;
            cmd_violation_q <= cmd_violation_d;
            rcd_q           <= rcd_d;
            ras_q           <= ras_d;
            rp_q            <= rp_d;
            ccd_l_q         <= ccd_l_d;
            rrd_l_q         <= rrd_l_d;
            ccd_s_q         <= ccd_s_d;
            rrd_s_q         <= rrd_s_d;
            wtr_q           <= wtr_d;
            faw_q           <= faw_d;
        end
    end

    assign bank_open     = bank_open_q;
    assign cmd_violation = cmd_violation_q;

endmodule
